// File: rtl/interrupt_controller.sv
// Fixed-priority 4-line interrupt controller: edge-latched pending flags, enable mask, vectored request, return-PC replay.
// A rise sampled at edge k is pending after k+2 and requested after k+3; int_req holds until ack, there is no timeout.
module interrupt_controller #(
    parameter logic [7:0] VEC_BASE   = 8'hF0,
    parameter int         VEC_STRIDE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] irq,
    input  logic       mask_wr,
    input  logic [3:0] mask_data,
    input  logic [7:0] pc,
    input  logic       ack,
    input  logic       reti,
    output logic       int_req,
    output logic [7:0] int_vector,
    output logic       ret_jmp,
    output logic [7:0] ret_addr,
    output logic [1:0] active_id,
    output logic       in_service,
    output logic [3:0] pending,
    output logic [3:0] mask
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE, RETURN} state_t;

    state_t     state_q, state_d;
    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;
    logic [3:0] sync3_q, sync3_d;
    logic [2:0] prime_q, prime_d;
    logic [3:0] pending_q, pending_d;
    logic [3:0] mask_q, mask_d;
    logic       int_req_q, int_req_d;
    logic [7:0] int_vector_q, int_vector_d;
    logic       ret_jmp_q, ret_jmp_d;
    logic [7:0] ret_addr_q, ret_addr_d;
    logic [1:0] active_id_q, active_id_d;
    logic       in_service_q, in_service_d;

    logic [3:0] rise;
    logic [3:0] elig;
    logic [3:0] clr;
    logic [1:0] sel_id;

    always_comb begin
        sync1_d      = irq;
        sync2_d      = sync1_q;
        sync3_d      = sync2_q;
        // Edges are only trusted once the whole chain holds real samples, so a
        // line held high across reset release does not look like a new rise.
        prime_d      = {prime_q[1:0], 1'b1};
        rise         = sync2_q & ~sync3_q & {4{prime_q[2]}};
        elig         = pending_q & mask_q;

        sel_id = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (elig[i]) begin
                sel_id = 2'(i);
            end
        end

        clr          = 4'b0000;
        state_d      = state_q;
        int_req_d    = int_req_q;
        int_vector_d = int_vector_q;
        ret_jmp_d    = ret_jmp_q;
        ret_addr_d   = ret_addr_q;
        active_id_d  = active_id_q;
        in_service_d = in_service_q;

        case (state_q)
            IDLE: begin
                if (elig != 4'b0000) begin
                    active_id_d  = sel_id;
                    int_vector_d = VEC_BASE + 8'(sel_id) * 8'(VEC_STRIDE);
                    int_req_d    = 1'b1;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (ack) begin
                    ret_addr_d   = pc;
                    clr          = 4'b0001 << active_id_q;
                    in_service_d = 1'b1;
                    int_req_d    = 1'b0;
                    state_d      = SERVICE;
                end
            end
            SERVICE: begin
                if (reti) begin
                    in_service_d = 1'b0;
                    ret_jmp_d    = 1'b1;
                    state_d      = RETURN;
                end
            end
            RETURN: begin
                ret_jmp_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A new rise in the same cycle as the ack clear keeps the flag set.
        pending_d = (pending_q & ~clr) | rise;
        mask_d    = mask_wr ? mask_data : mask_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            sync1_q      <= 4'b0000;
            sync2_q      <= 4'b0000;
            sync3_q      <= 4'b0000;
            prime_q      <= 3'b000;
            pending_q    <= 4'b0000;
            mask_q       <= 4'b0000;
            int_req_q    <= 1'b0;
            int_vector_q <= 8'h00;
            ret_jmp_q    <= 1'b0;
            ret_addr_q   <= 8'h00;
            active_id_q  <= 2'd0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            sync3_q      <= sync3_d;
            prime_q      <= prime_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            int_req_q    <= int_req_d;
            int_vector_q <= int_vector_d;
            ret_jmp_q    <= ret_jmp_d;
            ret_addr_q   <= ret_addr_d;
            active_id_q  <= active_id_d;
            in_service_q <= in_service_d;
        end
    end

    assign int_req    = int_req_q;
    assign int_vector = int_vector_q;
    assign ret_jmp    = ret_jmp_q;
    assign ret_addr   = ret_addr_q;
    assign active_id  = active_id_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;
    assign mask       = mask_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios with literal expectations, then random traffic,
// with every cycle compared against a sample-history / phase model of the controller.
module tb_interrupt_controller;

    localparam int VB = 240;
    localparam int VS = 4;
    localparam int P_IDLE = 0, P_REQ = 1, P_SVC = 2, P_RET = 3;

    logic       clk;
    logic       reset;
    logic [3:0] irq;
    logic       mask_wr;
    logic [3:0] mask_data;
    logic [7:0] pc;
    logic       ack;
    logic       reti;
    logic       int_req;
    logic [7:0] int_vector;
    logic       ret_jmp;
    logic [7:0] ret_addr;
    logic [1:0] active_id;
    logic       in_service;
    logic [3:0] pending;
    logic [3:0] mask;

    int total = 0;
    int bad   = 0;

    interrupt_controller #(.VEC_BASE(8'hF0), .VEC_STRIDE(4)) dut (
        .clk(clk), .reset(reset), .irq(irq), .mask_wr(mask_wr), .mask_data(mask_data),
        .pc(pc), .ack(ack), .reti(reti), .int_req(int_req), .int_vector(int_vector),
        .ret_jmp(ret_jmp), .ret_addr(ret_addr), .active_id(active_id),
        .in_service(in_service), .pending(pending), .mask(mask)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: pending derives from the history of irq samples taken since reset release.
    int       m_phase = P_IDLE;
    bit [3:0] m_pend  = 0;
    bit [3:0] m_mask  = 0;
    bit       m_req   = 0;
    bit       m_insvc = 0;
    bit       m_rj    = 0;
    bit [7:0] m_vec   = 0;
    bit [7:0] m_raddr = 0;
    int       m_id    = 0;
    bit [3:0] hist[$];

    task automatic model_clear();
        m_phase = P_IDLE; m_pend = 0; m_mask = 0; m_req = 0; m_insvc = 0;
        m_rj = 0; m_vec = 0; m_raddr = 0; m_id = 0;
        hist.delete();
    endtask

    task automatic model_step();
        bit [3:0] rise;
        bit [3:0] clr;
        bit [3:0] elig;
        int       id;
        rise = 4'b0000;
        clr  = 4'b0000;
        if (hist.size() >= 3)
            rise = hist[hist.size()-2] & ~hist[hist.size()-3];
        hist.push_back(irq);
        if (hist.size() > 8) void'(hist.pop_front());
        elig = m_pend & m_mask;
        case (m_phase)
            P_IDLE: if (elig != 0) begin
                id = 0;
                while (!elig[id]) id++;
                m_id    = id;
                m_vec   = 8'((VB + VS * id) % 256);
                m_req   = 1;
                m_phase = P_REQ;
            end
            P_REQ: if (ack) begin
                m_raddr = pc;
                clr     = 4'(1 << m_id);
                m_insvc = 1;
                m_req   = 0;
                m_phase = P_SVC;
            end
            P_SVC: if (reti) begin
                m_insvc = 0;
                m_rj    = 1;
                m_phase = P_RET;
            end
            default: begin
                m_rj    = 0;
                m_phase = P_IDLE;
            end
        endcase
        m_pend = (m_pend & ~clr) | rise;
        if (mask_wr) m_mask = mask_data;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_clear();
            else        model_step();
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("m.int_req",    32'(int_req),    32'(m_req));
        check("m.int_vector", 32'(int_vector), 32'(m_vec));
        check("m.ret_jmp",    32'(ret_jmp),    32'(m_rj));
        check("m.ret_addr",   32'(ret_addr),   32'(m_raddr));
        check("m.active_id",  32'(active_id),  32'(m_id));
        check("m.in_service", 32'(in_service), 32'(m_insvc));
        check("m.pending",    32'(pending),    32'(m_pend));
        check("m.mask",       32'(mask),       32'(m_mask));
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    initial begin
        reset = 1'b1; irq = 4'b0; mask_wr = 1'b0; mask_data = 4'b0;
        pc = 8'h00; ack = 1'b0; reti = 1'b0;
        fork
            forever begin
                @(negedge clk);
                compare_all();
            end
        join_none
        #1 reset = 1'b0;
        #1;
        check("rst.int_req", 32'(int_req), 0);
        check("rst.in_service", 32'(in_service), 0);
        check("rst.pending", 32'(pending), 0);
        check("rst.mask", 32'(mask), 0);
        check("rst.ret_jmp", 32'(ret_jmp), 0);
        check("rst.vector", 32'(int_vector), 0);
        cyc(2); reset = 1'b1; cyc(5);

        // 1: single pulse on irq[2]
        mask_wr = 1; mask_data = 4'hF; cyc(1); mask_wr = 0;
        check("t1.mask", 32'(mask), 32'hF);
        irq = 4'b0100; cyc(1); irq = 4'b0000; cyc(1);
        check("t1.pend_early", 32'(pending), 0);
        cyc(1);
        check("t1.pending", 32'(pending), 32'b0100);
        check("t1.req_early", 32'(int_req), 0);
        cyc(1);
        check("t1.int_req", 32'(int_req), 1);
        check("t1.id", 32'(active_id), 2);
        check("t1.vector", 32'(int_vector), 32'hF8);

        // 2: ack captures pc, reti replays it
        pc = 8'h37; ack = 1; cyc(1); ack = 0;
        check("t2.ret_addr", 32'(ret_addr), 32'h37);
        check("t2.pending", 32'(pending), 0);
        check("t2.in_service", 32'(in_service), 1);
        check("t2.int_req", 32'(int_req), 0);
        check("t2.vec_hold", 32'(int_vector), 32'hF8);
        cyc(2);
        reti = 1; cyc(1); reti = 0;
        check("t2.in_svc_off", 32'(in_service), 0);
        check("t2.ret_jmp", 32'(ret_jmp), 1);
        check("t2.ret_addr2", 32'(ret_addr), 32'h37);
        cyc(1);
        check("t2.ret_jmp_end", 32'(ret_jmp), 0);
        pc = 8'h99; ack = 1; cyc(1); ack = 0;
        check("t5.ack_idle_raddr", 32'(ret_addr), 32'h37);
        check("t5.ack_idle_svc", 32'(in_service), 0);

        // 3: simultaneous irq[3] and irq[1]
        irq = 4'b1010; cyc(1); irq = 4'b0000; cyc(3);
        check("t3.pending", 32'(pending), 32'b1010);
        check("t3.int_req", 32'(int_req), 1);
        check("t3.id", 32'(active_id), 1);
        check("t3.vector", 32'(int_vector), 32'hF4);
        reti = 1; cyc(1); reti = 0;
        check("t5.reti_req", 32'(int_req), 1);
        check("t5.reti_req_svc", 32'(in_service), 0);
        mask_wr = 1; mask_data = 4'h0; cyc(1); mask_wr = 0;
        check("t3.maskwr_req", 32'(int_req), 1);
        check("t3.maskwr_id", 32'(active_id), 1);
        mask_wr = 1; mask_data = 4'hF; cyc(1); mask_wr = 0;
        pc = 8'h52; ack = 1; cyc(1); ack = 0;
        check("t3.pend_left", 32'(pending), 32'b1000);
        reti = 1; cyc(1); reti = 0;
        check("t3.ret_addr", 32'(ret_addr), 32'h52);
        cyc(1);
        check("t3.idle_req", 32'(int_req), 0);
        cyc(1);
        check("t3.req2", 32'(int_req), 1);
        check("t3.id2", 32'(active_id), 3);
        check("t3.vector2", 32'(int_vector), 32'hFC);
        ack = 1; cyc(1); ack = 0; reti = 1; cyc(1); reti = 0; cyc(2);

        // 4: masked pending, released by mask write
        mask_wr = 1; mask_data = 4'h0; cyc(1); mask_wr = 0;
        irq = 4'b0001; cyc(1); irq = 4'b0000; cyc(4);
        check("t4.pending", 32'(pending), 32'b0001);
        check("t4.masked_req", 32'(int_req), 0);
        mask_wr = 1; mask_data = 4'b0001; cyc(1); mask_wr = 0;
        check("t4.req_at_wr", 32'(int_req), 0);
        cyc(1);
        check("t4.int_req", 32'(int_req), 1);
        check("t4.id", 32'(active_id), 0);
        check("t4.vector", 32'(int_vector), 32'hF0);

        // 5: no nesting during SERVICE
        pc = 8'h10; ack = 1; cyc(1); ack = 0;
        irq = 4'b0001; cyc(1); irq = 4'b0000; cyc(3);
        check("t5.pending", 32'(pending), 32'b0001);
        check("t5.no_nest", 32'(int_req), 0);
        reti = 1; cyc(1); reti = 0;
        check("t5.ret_req", 32'(int_req), 0);
        cyc(2);
        check("t5.refire", 32'(int_req), 1);
        check("t5.id", 32'(active_id), 0);

        // 6: asynchronous reset mid-REQ and mid-SERVICE
        irq = 4'b0010;
        #1 reset = 1'b0;
        #1;
        check("t6.req_int_req", 32'(int_req), 0);
        check("t6.req_pending", 32'(pending), 0);
        check("t6.req_mask", 32'(mask), 0);
        cyc(2); reset = 1'b1; cyc(8);
        check("t6.held_pend", 32'(pending), 0);
        check("t6.held_req", 32'(int_req), 0);
        mask_wr = 1; mask_data = 4'hF; cyc(1); mask_wr = 0;
        irq = 4'b0000; cyc(4);
        irq = 4'b0010; cyc(3);
        check("t6.new_rise", 32'(pending), 32'b0010);
        cyc(1);
        check("t6.req", 32'(int_req), 1);
        pc = 8'h61; ack = 1; cyc(1); ack = 0;
        check("t6.svc", 32'(in_service), 1);
        #1 reset = 1'b0;
        #1;
        check("t6.svc_in_service", 32'(in_service), 0);
        check("t6.svc_ret_jmp", 32'(ret_jmp), 0);
        check("t6.svc_ret_addr", 32'(ret_addr), 0);
        cyc(2); irq = 4'b0000; reset = 1'b1; cyc(5);

        // Random traffic
        mask_wr = 1; mask_data = 4'hF; cyc(1); mask_wr = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) irq = 4'($urandom_range(0, 15));
            mask_wr   = ($urandom_range(0, 19) == 0);
            mask_data = 4'($urandom_range(0, 15));
            ack       = ($urandom_range(0, 3) == 0);
            reti      = ($urandom_range(0, 4) == 0);
            pc        = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b0; cyc(2); reset = 1'b1;
            end
            cyc(1);
        end
        ack = 0; reti = 0; mask_wr = 0; irq = 4'b0;
        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
